// File: rtl/sumdiff_recover.sv
// Sum/diff recovery: joins S and D streams, recovers A=(S+D)>>>1, B=(S-D)>>>1
// per I/Q component, and forks the result to two independent outputs.
module sumdiff_recover #(
  parameter int WIDTH       = 16,
  parameter bit TLAST_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [2*WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [2*WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  output logic [2*WIDTH-1:0] a_tdata,
  output logic             a_tlast,
  output logic             a_tvalid,
  input  logic             a_tready,
  output logic [2*WIDTH-1:0] b_tdata,
  output logic             b_tlast,
  output logic             b_tvalid,
  input  logic             b_tready,
  output logic             tlast_err
);

  localparam int DW = 2 * WIDTH;

  // Widen by one bit so the add/sub never overflows, then drop the LSB.
  function automatic logic [WIDTH-1:0] half(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             sub
  );
    logic [WIDTH:0] xe;
    logic [WIDTH:0] ye;
    logic [WIDTH:0] r;
    xe = {x[WIDTH-1], x};
    ye = {y[WIDTH-1], y};
    r  = sub ? (xe - ye) : (xe + ye);
    return r[WIDTH:1];
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s_q, s_d;
  logic [DW-1:0] dif_q, dif_d;
  logic          s1_last_q, s1_last_d;

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          last_q, last_d;
  logic          a_pend_q, a_pend_d;
  logic          b_pend_q, b_pend_d;
  logic          err_q, err_d;

  logic s2_free;
  logic s1_adv;
  logic s1_ready;
  logic join_ok;

  logic [WIDTH-1:0] s_i, s_qc, d_i, d_qc;

  assign s2_free  = (!a_pend_q | a_tready) & (!b_pend_q | b_tready);
  assign s1_adv   = s1_valid_q & s2_free;
  assign s1_ready = !s1_valid_q | s1_adv;
  assign join_ok  = i0_tvalid & i1_tvalid & s1_ready & !clear & !reset;

  assign i0_tready = join_ok;
  assign i1_tready = join_ok;

  assign s_i  = s_q[DW-1:WIDTH];
  assign s_qc = s_q[WIDTH-1:0];
  assign d_i  = dif_q[DW-1:WIDTH];
  assign d_qc = dif_q[WIDTH-1:0];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s_d        = s_q;
    dif_d      = dif_q;
    s1_last_d  = s1_last_q;
    if (clear) begin
      s1_valid_d = 1'b0;
    end else if (join_ok) begin
      s1_valid_d = 1'b1;
      s_d        = i0_tdata;
      dif_d      = i1_tdata;
      s1_last_d  = i0_tlast;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    last_d   = last_q;
    a_pend_d = a_pend_q;
    b_pend_d = b_pend_q;
    if (clear) begin
      a_pend_d = 1'b0;
      b_pend_d = 1'b0;
    end else if (s1_adv) begin
      a_d      = {half(s_i, d_i, 1'b0), half(s_qc, d_qc, 1'b0)};
      b_d      = {half(s_i, d_i, 1'b1), half(s_qc, d_qc, 1'b1)};
      last_d   = s1_last_q;
      a_pend_d = 1'b1;
      b_pend_d = 1'b1;
    end else begin
      if (a_tready) a_pend_d = 1'b0;
      if (b_tready) b_pend_d = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (TLAST_CHECK && join_ok && (i0_tlast != i1_tlast)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s_q        <= '0;
      dif_q      <= '0;
      s1_last_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      last_q     <= 1'b0;
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s_q        <= s_d;
      dif_q      <= dif_d;
      s1_last_q  <= s1_last_d;
      a_q        <= a_d;
      b_q        <= b_d;
      last_q     <= last_d;
      a_pend_q   <= a_pend_d;
      b_pend_q   <= b_pend_d;
      err_q      <= err_d;
    end
  end

  assign a_tdata   = a_q;
  assign a_tlast   = last_q;
  assign a_tvalid  = a_pend_q;
  assign b_tdata   = b_q;
  assign b_tlast   = last_q;
  assign b_tvalid  = b_pend_q;
  assign tlast_err = err_q;

endmodule
